// File: rtl/bird_physics_if.sv
// Frame-tick link between the frame-rate divider (master) and the bird motion engine (slave).
// frameTick is a one-cycle request with no backpressure; the slave always accepts it and answers
// with a one-cycle updateDone the cycle after a tick that actually moved the bird.
interface bird_physics_if;
  logic frameTick;
  logic updateDone;

  modport master (output frameTick, input updateDone);
  modport slave  (input frameTick, output updateDone);
endinterface

// File: rtl/bird_physics.sv
// Per-frame bird motion engine: gravity, flap impulse, ceiling/floor clamps and the
// idle/play/dead game state that drives rendering and scoring.
module bird_physics #(
  parameter int SCREEN_H     = 120,
  parameter int BIRD_H       = 8,
  parameter int START_Y      = 56,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 5,
  parameter int MAX_FALL     = 4,
  parameter int Y_W          = 7
) (
  input  logic                  frameClock,
  input  logic                  resetLow,
  bird_physics_if.slave         tickBus,
  input  logic                  flap,
  input  logic                  collision,
  output logic [Y_W-1:0]        birdY,
  output logic signed [4:0]     birdVel,
  output logic                  playing,
  output logic                  dead,
  output logic [1:0]            debugState
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [Y_W-1:0]        FLOOR_Y   = Y_W'(SCREEN_H - BIRD_H);
  localparam logic signed [Y_W+1:0] FLOOR_S   = (Y_W+2)'(SCREEN_H - BIRD_H);
  localparam logic [Y_W-1:0]        START_V   = Y_W'(START_Y);
  localparam logic signed [5:0]     GRAV_S    = 6'(GRAVITY);
  localparam logic signed [5:0]     MAXFALL_S = 6'(MAX_FALL);
  localparam logic signed [4:0]     FLAP_VEL  = 5'(-FLAP_IMPULSE);

  state_t state, nextState;
  logic [Y_W-1:0]        nextY;
  logic signed [4:0]     nextVel, newVel, gravVel;
  logic signed [5:0]     velInc;
  logic signed [Y_W+1:0] newY;
  logic flapPrev, flapArmed, flapPending, nextPending, flapEdge, pendEff;
  logic updateDoneQ, nextDone;

  // flapArmed keeps a button held through reset from counting as a fresh press.
  assign flapEdge = flap & ~flapPrev & flapArmed;
  assign pendEff  = flapPending | flapEdge;

  always_comb begin
    velInc  = {birdVel[4], birdVel} + GRAV_S;
    gravVel = (velInc > MAXFALL_S) ? MAXFALL_S[4:0] : velInc[4:0];
    newVel  = pendEff ? FLAP_VEL : gravVel;
    newY    = $signed({2'b00, birdY}) + $signed({{(Y_W-3){newVel[4]}}, newVel});
  end

  always_comb begin
    nextState   = state;
    nextY       = birdY;
    nextVel     = birdVel;
    nextPending = flapPending;
    nextDone    = 1'b0;
    case (state)
      IDLE: begin
        nextY   = START_V;
        nextVel = '0;
        if (flapEdge) begin
          nextState   = PLAY;
          nextPending = 1'b1;
        end
      end
      PLAY: begin
        if (collision) begin
          // Collision wins over a coincident tick; that tick is dropped.
          nextState   = DEAD;
          nextVel     = '0;
          nextPending = 1'b0;
        end else if (tickBus.frameTick) begin
          nextDone    = 1'b1;
          nextPending = 1'b0;
          if (newY[Y_W+1]) begin
            nextY   = '0;
            nextVel = newVel;
          end else if (newY >= FLOOR_S) begin
            nextY     = FLOOR_Y;
            nextVel   = '0;
            nextState = DEAD;
          end else begin
            nextY   = newY[Y_W-1:0];
            nextVel = newVel;
          end
        end else if (flapEdge) begin
          nextPending = 1'b1;
        end
      end
      DEAD: begin
        nextVel     = '0;
        nextPending = 1'b0;
        if (flapEdge) begin
          nextState = IDLE;
          nextY     = START_V;
        end
      end
      default: begin
        nextState   = IDLE;
        nextY       = START_V;
        nextVel     = '0;
        nextPending = 1'b0;
      end
    endcase
  end

  always_ff @(posedge frameClock or negedge resetLow) begin
    if (!resetLow) begin
      state       <= IDLE;
      birdY       <= START_V;
      birdVel     <= '0;
      flapPending <= 1'b0;
      flapPrev    <= 1'b0;
      flapArmed   <= 1'b0;
      updateDoneQ <= 1'b0;
      playing     <= 1'b0;
      dead        <= 1'b0;
    end else begin
      state       <= nextState;
      birdY       <= nextY;
      birdVel     <= nextVel;
      flapPending <= nextPending;
      flapPrev    <= flap;
      flapArmed   <= flapArmed | ~flap;
      updateDoneQ <= nextDone;
      playing     <= (nextState == PLAY);
      dead        <= (nextState == DEAD);
    end
  end

  assign tickBus.updateDone = updateDoneQ;
  assign debugState         = state;

endmodule

// File: tb/tb_bird_physics.sv
// Directed, table-driven bench for bird_physics: every step drives tick/flap/collision on the
// falling edge and compares all outputs just after the next rising edge.
module tb_bird_physics;
  logic frameClock;
  logic resetLow;
  logic flap;
  logic collision;
  logic [6:0] birdY;
  logic signed [4:0] birdVel;
  logic playing;
  logic dead;
  logic [1:0] debugState;

  bird_physics_if tickBus ();

  bird_physics dut (
    .frameClock (frameClock),
    .resetLow   (resetLow),
    .tickBus    (tickBus),
    .flap       (flap),
    .collision  (collision),
    .birdY      (birdY),
    .birdVel    (birdVel),
    .playing    (playing),
    .dead       (dead),
    .debugState (debugState)
  );

  initial frameClock = 1'b0;
  always #5 frameClock = ~frameClock;

  typedef struct {
    logic tick;
    logic flapIn;
    logic coll;
    int   y;
    int   vel;
    logic play;
    logic dd;
    logic done;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic t, input logic f, input logic c, input int y,
                              input int v, input logic p, input logic d, input logic u);
    vec_t e;
    e.tick = t; e.flapIn = f; e.coll = c; e.y = y; e.vel = v;
    e.play = p; e.dd = d; e.done = u;
    return e;
  endfunction

  task automatic add(input logic t, input logic f, input logic c, input int y, input int v,
                     input logic p, input logic d, input logic u);
    vecs.push_back(mk(t, f, c, y, v, p, d, u));
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, ".birdY"}, int'(birdY), e.y);
    check({tag, ".birdVel"}, int'(birdVel), e.vel);
    check({tag, ".playing"}, int'(playing), int'(e.play));
    check({tag, ".dead"}, int'(dead), int'(e.dd));
    check({tag, ".updateDone"}, int'(tickBus.updateDone), int'(e.done));
  endtask

  task automatic apply(input string tag, input vec_t e);
    @(negedge frameClock);
    tickBus.frameTick = e.tick;
    flap              = e.flapIn;
    collision         = e.coll;
    @(posedge frameClock);
    #1;
    check_outputs(tag, e);
  endtask

  initial begin
    int fy[25] = '{51, 47, 44, 42, 41, 41, 42, 44, 47, 51, 55, 59, 63, 67, 71,
                   75, 79, 83, 87, 91, 95, 99, 103, 107, 111};
    int fv[25] = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 4, 4, 4, 4, 4,
                   4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

    // Idle: ticks are ignored.
    add(1, 0, 0, 56, 0, 0, 0, 0);
    add(0, 0, 0, 56, 0, 0, 0, 0);
    add(1, 0, 0, 56, 0, 0, 0, 0);
    // Flap then coast, with flap held across the second tick.
    add(0, 1, 0, 56, 0, 1, 0, 0);
    add(1, 1, 0, 51, -5, 1, 0, 1);
    add(0, 1, 0, 51, -5, 1, 0, 0);
    add(1, 1, 0, 47, -4, 1, 0, 1);
    add(0, 0, 0, 47, -4, 1, 0, 0);
    add(1, 0, 0, 44, -3, 1, 0, 1);
    add(0, 0, 0, 44, -3, 1, 0, 0);
    // Collision together with a tick, then a dead tick, then restart to idle.
    add(1, 0, 1, 44, 0, 0, 1, 0);
    add(1, 0, 0, 44, 0, 0, 1, 0);
    add(0, 1, 0, 56, 0, 0, 0, 0);
    add(0, 0, 0, 56, 0, 0, 0, 0);
    // Fall to the floor.
    add(0, 1, 0, 56, 0, 1, 0, 0);
    for (int i = 0; i < 25; i++) begin
      add(1, 0, 0, fy[i], fv[i], 1, 0, 1);
      add(0, 0, 0, fy[i], fv[i], 1, 0, 0);
    end
    add(1, 0, 0, 112, 0, 0, 1, 1);
    add(0, 0, 0, 112, 0, 0, 1, 0);
    add(1, 0, 0, 112, 0, 0, 1, 0);
    // Back to idle, start again, then flap on every tick up to the ceiling.
    add(0, 1, 0, 56, 0, 0, 0, 0);
    add(0, 0, 0, 56, 0, 0, 0, 0);
    add(0, 1, 0, 56, 0, 1, 0, 0);
    add(0, 0, 0, 56, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      add(1, 1, 0, (i < 11) ? 51 - 5 * i : 0, -5, 1, 0, 1);
      add(0, 0, 0, (i < 11) ? 51 - 5 * i : 0, -5, 1, 0, 0);
    end
    // At the ceiling: gravity step stays clamped, then a flap pressed between ticks.
    add(1, 0, 0, 0, -4, 1, 0, 1);
    add(0, 0, 0, 0, -4, 1, 0, 0);
    add(0, 1, 0, 0, -4, 1, 0, 0);
    add(0, 0, 0, 0, -4, 1, 0, 0);
    add(1, 0, 0, 0, -5, 1, 0, 1);
    add(0, 0, 0, 0, -5, 1, 0, 0);

    resetLow          = 1'b0;
    flap              = 1'b0;
    collision         = 1'b0;
    tickBus.frameTick = 1'b0;
    #12;
    check_outputs("reset", mk(0, 0, 0, 56, 0, 0, 0, 0));
    @(negedge frameClock);
    resetLow = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset between edges while playing, with flap held through it.
    @(negedge frameClock);
    flap = 1'b1;
    #2;
    resetLow = 1'b0;
    #1;
    check_outputs("async_reset", mk(0, 0, 0, 56, 0, 0, 0, 0));
    @(negedge frameClock);
    resetLow = 1'b1;
    apply("stale_flap0", mk(0, 1, 0, 56, 0, 0, 0, 0));
    apply("stale_flap1", mk(0, 1, 0, 56, 0, 0, 0, 0));
    apply("release", mk(0, 0, 0, 56, 0, 0, 0, 0));
    apply("repress", mk(0, 1, 0, 56, 0, 1, 0, 0));
    apply("first_tick", mk(1, 0, 0, 51, -5, 1, 0, 1));
    apply("after_tick", mk(0, 0, 0, 51, -5, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
